// File: rtl/layer_input_streamer.sv
// rtl/layer_input_streamer.sv - double-buffered layer input store replaying one vector per freeze window
// Writes fill two banks by element count; a read FSM streams a full bank to the neurons and pulses layer_done.
module layer_input_streamer #(
   parameter int NUM_INPUTS = 784,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [DATA_WIDTH-1:0] i_in_data,
   input  logic                  i_in_valid,
   output logic                  o_in_ready,
   input  logic                  i_in_last,
   output logic                  o_freeze,
   output logic [DATA_WIDTH-1:0] o_data_out,
   output logic                  o_layer_done,
   output logic                  o_busy,
   output logic                  o_err_len
);

   localparam int CNT_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_INPUTS - 1);

   typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

   logic [DATA_WIDTH-1:0] r_bank0 [NUM_INPUTS];
   logic [DATA_WIDTH-1:0] r_bank1 [NUM_INPUTS];

   logic [1:0]            r_full;
   logic                  r_wr_bank;
   logic                  r_rd_bank;
   logic [CNT_W-1:0]      r_wr_cnt;
   logic [CNT_W-1:0]      r_rd_cnt;
   logic                  r_err_len;
   state_t                r_state;
   logic                  r_freeze;
   logic [DATA_WIDTH-1:0] r_data_out;
   logic                  r_layer_done;

   state_t                w_state_nxt;
   logic                  w_freeze_nxt;
   logic [DATA_WIDTH-1:0] w_data_nxt;
   logic                  w_done_nxt;
   logic [CNT_W-1:0]      w_rd_cnt_nxt;
   logic                  w_rd_release;
   logic                  w_wr_fire;
   logic                  w_wr_last;
   logic [CNT_W-1:0]      w_rd_idx;
   logic [DATA_WIDTH-1:0] w_rd_data;

   assign o_in_ready = ~r_full[r_wr_bank];
   assign w_wr_fire  = i_in_valid & o_in_ready;
   assign w_wr_last  = (r_wr_cnt == LAST_IDX);

   always_ff @(posedge i_clk) begin
      if (w_wr_fire) begin
         if (r_wr_bank) r_bank1[r_wr_cnt] <= i_in_data;
         else           r_bank0[r_wr_cnt] <= i_in_data;
      end
   end

   // Set and clear never target the same bank: set needs it empty, clear needs it full.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_full    <= '0;
         r_wr_bank <= 1'b0;
         r_wr_cnt  <= '0;
         r_err_len <= 1'b0;
      end else begin
         if (w_rd_release) r_full[r_rd_bank] <= 1'b0;
         if (w_wr_fire) begin
            if (i_in_last != w_wr_last) r_err_len <= 1'b1;
            if (w_wr_last) begin
               r_full[r_wr_bank] <= 1'b1;
               r_wr_cnt          <= '0;
               r_wr_bank         <= ~r_wr_bank;
            end else begin
               r_wr_cnt <= r_wr_cnt + CNT_W'(1);
            end
         end
      end
   end

   // Prefetch the element for the next window cycle so data_out stays aligned with freeze.
   assign w_rd_idx  = (r_state == S_STREAM && r_rd_cnt != LAST_IDX) ? r_rd_cnt + CNT_W'(1) : '0;
   assign w_rd_data = r_rd_bank ? r_bank1[w_rd_idx] : r_bank0[w_rd_idx];

   always_comb begin
      w_state_nxt  = r_state;
      w_freeze_nxt = 1'b1;
      w_data_nxt   = '0;
      w_done_nxt   = 1'b0;
      w_rd_cnt_nxt = '0;
      w_rd_release = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (r_full[r_rd_bank]) begin
               w_state_nxt  = S_STREAM;
               w_freeze_nxt = 1'b0;
               w_data_nxt   = w_rd_data;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_STREAM: begin
            if (r_rd_cnt == LAST_IDX) begin
               w_state_nxt  = S_DONE;
               w_done_nxt   = 1'b1;
               w_rd_release = 1'b1;
            end else begin
               w_freeze_nxt = 1'b0;
               w_data_nxt   = w_rd_data;
               w_rd_cnt_nxt = r_rd_cnt + CNT_W'(1);
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= S_IDLE;
         r_freeze     <= 1'b1;
         r_data_out   <= '0;
         r_layer_done <= 1'b0;
         r_rd_cnt     <= '0;
         r_rd_bank    <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_freeze     <= w_freeze_nxt;
         r_data_out   <= w_data_nxt;
         r_layer_done <= w_done_nxt;
         r_rd_cnt     <= w_rd_cnt_nxt;
         if (w_rd_release) r_rd_bank <= ~r_rd_bank;
      end
   end

   assign o_freeze     = r_freeze;
   assign o_data_out   = r_data_out;
   assign o_layer_done = r_layer_done;
   assign o_err_len    = r_err_len;
   assign o_busy       = (r_state != S_IDLE) | r_full[0] | r_full[1];

endmodule

// File: doc/layer_input_streamer.md
Name: layer_input_streamer

Overview:
- Upstream feeder for one layer of neuron instances.
- Accepts a layer input vector (from the image loader or the previous layer's ReLU outputs) over a valid/ready stream into a double-buffered store.
- Replays each vector as one element per cycle on the shared neuron data input, with a freeze window lasting exactly NUM_INPUTS cycles.
- Pulses layer_done when every neuron's accumulator, bias included, is final.

Parameters:
NUM_INPUTS, 784, elements per vector; equals the neurons' weight count.
DATA_WIDTH, 16, element width; signed fixed point, opaque to this block.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
in_data  input  DATA_WIDTH  incoming vector element.
in_valid  input  1  in_data valid.
in_ready  output  1  block can accept in_data.
in_last  input  1  producer marks final element of a vector.
freeze  output  1  to every neuron in the layer: 1 = hold/clear address, 0 = accumulate.
data_out  output  DATA_WIDTH  to every neuron's data input.
layer_done  output  1  one-cycle pulse: neuron sums are final.
busy  output  1  any bank full or stream in progress.
err_len  output  1  sticky: in_last position mismatch.

Behaviour:
Reset (asynchronous, takes effect immediately):
- Outputs: freeze=1, data_out=0, layer_done=0, err_len=0, busy=0.
- Both bank-full flags, wr_cnt, rd_cnt, wr_bank and rd_bank clear to 0; in_ready=1 after reset.
- Bank contents are not reset.
- Reset mid-stream abandons the vector; the freeze=1 level clears the neurons.

Write side:
- Two banks of NUM_INPUTS x DATA_WIDTH.
- in_ready = !full[wr_bank], combinational.
- Handshake = in_valid & in_ready at a rising edge.
- On each handshake: store in_data at bank[wr_bank][wr_cnt] and increment wr_cnt.
- At wr_cnt==NUM_INPUTS-1 on a handshake: set full[wr_bank], wr_cnt<=0, toggle wr_bank.
- The element count alone defines vector boundaries.
- If in_last is high on a handshake with wr_cnt!=NUM_INPUTS-1, or low with wr_cnt==NUM_INPUTS-1, set err_len (sticky until reset).

Read FSM (states IDLE, STREAM, DONE; all outputs registered):
- IDLE:
  - freeze=1.
  - If full[rd_bank]: go to STREAM; freeze<=0 and data_out<=bank[rd_bank][0] at the same edge.
- STREAM:
  - During the k-th cycle of the window (k=0..NUM_INPUTS-1), freeze=0 and data_out=element k of that bank.
  - Exactly NUM_INPUTS cycles; prefetch as needed so data and freeze stay aligned.
  - At the edge ending element NUM_INPUTS-1: clear full[rd_bank], toggle rd_bank, freeze<=1, data_out<=0, layer_done<=1, go to DONE.
- DONE:
  - freeze=1, layer_done=1 for exactly one cycle. This cycle is the mandatory freeze gap that resets neuron state and address.
  - Next: STREAM if full[rd_bank] (back-to-back, minimum gap one cycle), else IDLE.

Timing:
- Latency: handshake of element NUM_INPUTS-1 at edge E; freeze falls at edge E+1 if IDLE.
- freeze must never stay low longer than NUM_INPUTS cycles; it wraps the neuron address.
- layer_done means neuron sums are valid now and held while freeze=1. Downstream captures them on the edge ending the layer_done cycle or later.

Simultaneous events and boundaries:
- A bank freed at an edge is writable from the following cycle.
- Writing one bank while streaming the other is permitted. No collision is possible since wr_bank==rd_bank only when that bank is empty or full respectively.
- Both banks full: in_ready=0, producer stalls, no data loss.
- in_valid with in_ready=0: no state change.
- busy = (state!=IDLE) | full[0] | full[1].

Test Plan:
- NUM_INPUTS=4; reset then push 1,2,3,4 one per cycle, in_last on 4 -> freeze low exactly 4 cycles with data_out 1,2,3,4 starting one edge after the last handshake; layer_done pulses once in the following cycle with freeze=1; err_len=0.
- Push two vectors (10..13, 20..23) continuously -> second streams after exactly one freeze=1 DONE cycle; in_ready drops only if both banks are full; two layer_done pulses.
- Push three vectors with no gaps while streaming -> in_ready=0 during the third until a bank frees; all 12 elements appear in order; no loss or duplication.
- in_last asserted on element index 2 of 4 -> err_len=1 and remains 1; streaming of that vector still outputs 4 elements.
- Assert rst_n=0 in stream cycle 2 -> freeze=1, data_out=0, in_ready=1 immediately; after release a fresh vector 5,6,7,8 streams correctly.
- With 4 neuron instances attached (known weights/bias), stream a vector -> neuron sum_out at layer_done equals the software dot product plus bias.
